scr1_mem_arbiter: RTL and testbench

- Two-master to one-slave arbiter on the SCR1 memory interface. The interface uses a req/req_ack address phase and a resp data phase.
- Lets the IMEM and DMEM paths, or two DMEM router ports, share one memory/bridge port.
- One transaction outstanding at a time. Back-to-back handoff is allowed on RDY_OK.
- A response-timeout watchdog returns RDY_ER to a stalled master, then drains the late slave response.

---
 rtl/scr1_mem_arbiter_pkg.sv | 27 ++
 rtl/scr1_arb_rr2.sv | 21 ++
 rtl/scr1_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_scr1_mem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_mem_arbiter_pkg.sv
// Shared memory-interface enums and defaults for the two-master SCR1 memory arbiter.
package scr1_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    SCR1_MEM_CMD_RD    = 2'b00,
    SCR1_MEM_CMD_WR    = 2'b01,
    SCR1_MEM_CMD_ERROR = 2'b11
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  localparam int unsigned SCR1_ARB_AWIDTH_DEF  = 32;
  localparam int unsigned SCR1_ARB_DWIDTH_DEF  = 32;
  localparam int unsigned SCR1_ARB_TIMEOUT_DEF = 0;

endpackage

// File: rtl/scr1_arb_rr2.sv
// Two-way request picker: a lone requester wins; on contention round-robin
// favours the master not granted last, fixed priority favours master 1.
module scr1_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_mode,
  output logic       grant
);

  // Grant selection
  always_comb begin
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = rr_mode ? ~last : 1'b1;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/scr1_mem_arbiter.sv
// Two-master to one-slave SCR1 memory arbiter with a single outstanding transaction,
// zero-bubble handoff on RDY_OK and an optional response-timeout watchdog.
module scr1_mem_arbiter
  import scr1_mem_arbiter_pkg::*;
#(
  parameter int unsigned SCR1_ARB_AWIDTH  = SCR1_ARB_AWIDTH_DEF,
  parameter int unsigned SCR1_ARB_DWIDTH  = SCR1_ARB_DWIDTH_DEF,
  parameter int unsigned SCR1_ARB_RR      = 1,
  parameter int unsigned SCR1_ARB_TIMEOUT = SCR1_ARB_TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       m0_req,
  output logic                       m0_req_ack,
  input  type_scr1_mem_cmd_e         m0_cmd,
  input  type_scr1_mem_width_e       m0_width,
  input  logic [SCR1_ARB_AWIDTH-1:0] m0_addr,
  input  logic [SCR1_ARB_DWIDTH-1:0] m0_wdata,
  output logic [SCR1_ARB_DWIDTH-1:0] m0_rdata,
  output type_scr1_mem_resp_e        m0_resp,
  input  logic                       m1_req,
  output logic                       m1_req_ack,
  input  type_scr1_mem_cmd_e         m1_cmd,
  input  type_scr1_mem_width_e       m1_width,
  input  logic [SCR1_ARB_AWIDTH-1:0] m1_addr,
  input  logic [SCR1_ARB_DWIDTH-1:0] m1_wdata,
  output logic [SCR1_ARB_DWIDTH-1:0] m1_rdata,
  output type_scr1_mem_resp_e        m1_resp,
  output logic                       mem_req,
  input  logic                       mem_req_ack,
  output type_scr1_mem_cmd_e         mem_cmd,
  output type_scr1_mem_width_e       mem_width,
  output logic [SCR1_ARB_AWIDTH-1:0] mem_addr,
  output logic [SCR1_ARB_DWIDTH-1:0] mem_wdata,
  input  logic [SCR1_ARB_DWIDTH-1:0] mem_rdata,
  input  type_scr1_mem_resp_e        mem_resp,
  output logic                       arb_timeout
);

  typedef enum logic [1:0] {
    ARB_ADDR  = 2'b00,
    ARB_DATA  = 2'b01,
    ARB_DRAIN = 2'b10
  } arb_fsm_e;

  localparam logic        RR_MODE  = (SCR1_ARB_RR != 0);
  localparam logic        TMO_EN   = (SCR1_ARB_TIMEOUT != 0);
  localparam logic [15:0] TMO_LAST = 16'(SCR1_ARB_TIMEOUT - 32'd1);

  arb_fsm_e    fsm_q, fsm_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        arb_timeout_q, arb_timeout_d;

  logic        any_req_s, window_s, grant_s, hs_s, fire_s;

  scr1_arb_rr2 u_pick (
    .req     ({m1_req, m0_req}),
    .last    (last_q),
    .rr_mode (RR_MODE),
    .grant   (grant_s)
  );

  assign any_req_s = m0_req | m1_req;
  assign window_s  = (fsm_q == ARB_ADDR) ||
                     ((fsm_q == ARB_DATA) && (mem_resp == SCR1_MEM_RESP_RDY_OK));
  assign hs_s      = mem_req & mem_req_ack;
  assign fire_s    = TMO_EN && (fsm_q == ARB_DATA) &&
                     (mem_resp == SCR1_MEM_RESP_NOTRDY) && (tmo_cnt_q == TMO_LAST);
  assign arb_timeout = arb_timeout_q;

  // Address phase: forward the granted master while the window is open
  always_comb begin
    mem_req    = window_s & any_req_s;
    m0_req_ack = window_s & any_req_s & ~grant_s & mem_req_ack;
    m1_req_ack = window_s & any_req_s &  grant_s & mem_req_ack;
    if (!any_req_s) begin
      mem_cmd   = SCR1_MEM_CMD_ERROR;
      mem_width = SCR1_MEM_WIDTH_ERROR;
      mem_addr  = {SCR1_ARB_AWIDTH{1'b0}};
      mem_wdata = {SCR1_ARB_DWIDTH{1'b0}};
    end else if (grant_s) begin
      mem_cmd   = m1_cmd;
      mem_width = m1_width;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end else begin
      mem_cmd   = m0_cmd;
      mem_width = m0_width;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end
  end

  // Data phase: only the owner sees the slave; a watchdog hit reads as RDY_ER
  always_comb begin
    m0_resp  = SCR1_MEM_RESP_NOTRDY;
    m1_resp  = SCR1_MEM_RESP_NOTRDY;
    m0_rdata = {SCR1_ARB_DWIDTH{1'b0}};
    m1_rdata = {SCR1_ARB_DWIDTH{1'b0}};
    if (fsm_q == ARB_DATA) begin
      if (owner_q) begin
        m1_resp  = fire_s ? SCR1_MEM_RESP_RDY_ER : mem_resp;
        m1_rdata = mem_rdata;
      end else begin
        m0_resp  = fire_s ? SCR1_MEM_RESP_RDY_ER : mem_resp;
        m0_rdata = mem_rdata;
      end
    end else begin
      m0_resp = SCR1_MEM_RESP_NOTRDY;
    end
  end

  // Next-state logic
  always_comb begin
    fsm_d         = fsm_q;
    owner_d       = owner_q;
    last_d        = last_q;
    tmo_cnt_d     = tmo_cnt_q;
    arb_timeout_d = 1'b0;
    case (fsm_q)
      ARB_ADDR, ARB_DATA: begin
        if (hs_s) begin
          fsm_d     = ARB_DATA;
          owner_d   = grant_s;
          last_d    = grant_s;
          tmo_cnt_d = 16'd0;
        end else if (fsm_q == ARB_ADDR) begin
          fsm_d = ARB_ADDR;
        end else if (mem_resp != SCR1_MEM_RESP_NOTRDY) begin
          fsm_d = ARB_ADDR;
        end else if (fire_s) begin
          fsm_d         = ARB_DRAIN;
          arb_timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      ARB_DRAIN: begin
        if (mem_resp != SCR1_MEM_RESP_NOTRDY) begin
          fsm_d = ARB_ADDR;
        end else begin
          fsm_d = ARB_DRAIN;
        end
      end
      default: fsm_d = ARB_ADDR;
    endcase
  end

  // State registers; last_q resets to 1 so the first contention grants master 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q         <= ARB_ADDR;
      owner_q       <= 1'b0;
      last_q        <= 1'b1;
      tmo_cnt_q     <= 16'd0;
      arb_timeout_q <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      tmo_cnt_q     <= tmo_cnt_d;
      arb_timeout_q <= arb_timeout_d;
    end
  end

endmodule

// File: tb/tb_scr1_mem_arbiter.sv
// Bench for scr1_mem_arbiter: instance 0 is round-robin with a 4-cycle watchdog,
// instance 1 is fixed priority without watchdog; both share the same stimulus.
module tb_scr1_mem_arbiter;
  import scr1_mem_arbiter_pkg::*;

  logic                 clk, rst_n;
  logic                 m0_req, m1_req, mem_req_ack;
  type_scr1_mem_cmd_e   m0_cmd, m1_cmd;
  type_scr1_mem_width_e m0_width, m1_width;
  logic [31:0]          m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rdata;
  type_scr1_mem_resp_e  mem_resp;

  logic                 m0_ack_w [2];
  logic                 m1_ack_w [2];
  logic [31:0]          m0_rdata_w [2];
  logic [31:0]          m1_rdata_w [2];
  type_scr1_mem_resp_e  m0_resp_w [2];
  type_scr1_mem_resp_e  m1_resp_w [2];
  logic                 mem_req_w [2];
  type_scr1_mem_cmd_e   mem_cmd_w [2];
  type_scr1_mem_width_e mem_width_w [2];
  logic [31:0]          mem_addr_w [2];
  logic [31:0]          mem_wdata_w [2];
  logic                 tmo_w [2];

  int n_checks = 0;
  int n_fail   = 0;

  scr1_mem_arbiter #(.SCR1_ARB_AWIDTH(32), .SCR1_ARB_DWIDTH(32),
                     .SCR1_ARB_RR(1), .SCR1_ARB_TIMEOUT(4)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_req_ack(m0_ack_w[0]), .m0_cmd(m0_cmd), .m0_width(m0_width),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata_w[0]), .m0_resp(m0_resp_w[0]),
    .m1_req(m1_req), .m1_req_ack(m1_ack_w[0]), .m1_cmd(m1_cmd), .m1_width(m1_width),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata_w[0]), .m1_resp(m1_resp_w[0]),
    .mem_req(mem_req_w[0]), .mem_req_ack(mem_req_ack), .mem_cmd(mem_cmd_w[0]),
    .mem_width(mem_width_w[0]), .mem_addr(mem_addr_w[0]), .mem_wdata(mem_wdata_w[0]),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .arb_timeout(tmo_w[0])
  );

  scr1_mem_arbiter #(.SCR1_ARB_AWIDTH(32), .SCR1_ARB_DWIDTH(32),
                     .SCR1_ARB_RR(0), .SCR1_ARB_TIMEOUT(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_req_ack(m0_ack_w[1]), .m0_cmd(m0_cmd), .m0_width(m0_width),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata_w[1]), .m0_resp(m0_resp_w[1]),
    .m1_req(m1_req), .m1_req_ack(m1_ack_w[1]), .m1_cmd(m1_cmd), .m1_width(m1_width),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata_w[1]), .m1_resp(m1_resp_w[1]),
    .mem_req(mem_req_w[1]), .mem_req_ack(mem_req_ack), .mem_cmd(mem_cmd_w[1]),
    .mem_width(mem_width_w[1]), .mem_addr(mem_addr_w[1]), .mem_wdata(mem_wdata_w[1]),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .arb_timeout(tmo_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    m0_req = 1'b0; m1_req = 1'b0; mem_req_ack = 1'b0;
    m0_cmd = SCR1_MEM_CMD_RD; m1_cmd = SCR1_MEM_CMD_RD;
    m0_width = SCR1_MEM_WIDTH_WORD; m1_width = SCR1_MEM_WIDTH_WORD;
    m0_addr = 32'h0; m1_addr = 32'h0; m0_wdata = 32'h0; m1_wdata = 32'h0;
    mem_rdata = 32'h0; mem_resp = SCR1_MEM_RESP_NOTRDY;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    mem_resp = SCR1_MEM_RESP_RDY_OK;
    @(negedge clk); #1;
    n_checks++;
    if ({mem_req_w[0], m0_resp_w[0], m1_resp_w[0], tmo_w[0]} !==
        {1'b0, SCR1_MEM_RESP_NOTRDY, SCR1_MEM_RESP_NOTRDY, 1'b0}) begin
      n_fail++; $display("FAIL reset_outputs: got req=%b r0=%0d r1=%0d tmo=%b, expected 0/0/0/0",
                         mem_req_w[0], m0_resp_w[0], m1_resp_w[0], tmo_w[0]);
    end
    n_checks++;
    if (mem_cmd_w[0] !== SCR1_MEM_CMD_ERROR || mem_addr_w[0] !== 32'h0) begin
      n_fail++; $display("FAIL reset_idle_fields: got cmd=%0d addr=%h, expected 3/0", mem_cmd_w[0], mem_addr_w[0]);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int acks = 0;
    do_reset();
    @(negedge clk);
    m0_req = 1'b1; m0_cmd = SCR1_MEM_CMD_RD; m0_addr = 32'h100; mem_req_ack = 1'b1;
    #1;
    acks += int'(m0_ack_w[0]);
    n_checks++;
    if ({mem_req_w[0], m0_ack_w[0], m1_ack_w[0], mem_addr_w[0], mem_cmd_w[0]} !==
        {1'b1, 1'b1, 1'b0, 32'h100, SCR1_MEM_CMD_RD}) begin
      n_fail++; $display("FAIL single_addr: got req=%b a0=%b a1=%b addr=%h, expected 1/1/0/100",
                         mem_req_w[0], m0_ack_w[0], m1_ack_w[0], mem_addr_w[0]);
    end
    @(negedge clk);
    m0_req = 1'b0; mem_req_ack = 1'b0; mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'hDEADBEEF;
    #1;
    acks += int'(m0_ack_w[0]);
    n_checks++;
    if ({m0_resp_w[0], m0_rdata_w[0], m1_resp_w[0], m1_rdata_w[0]} !==
        {SCR1_MEM_RESP_RDY_OK, 32'hDEADBEEF, SCR1_MEM_RESP_NOTRDY, 32'h0}) begin
      n_fail++; $display("FAIL single_data: got r0=%0d d0=%h r1=%0d d1=%h, expected 1/deadbeef/0/0",
                         m0_resp_w[0], m0_rdata_w[0], m1_resp_w[0], m1_rdata_w[0]);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    acks += int'(m0_ack_w[0]);
    n_checks++;
    if (m0_resp_w[0] !== SCR1_MEM_RESP_NOTRDY || acks != 1) begin
      n_fail++; $display("FAIL single_done: got r0=%0d acks=%0d, expected 0/1", m0_resp_w[0], acks);
    end
  endtask

  task automatic test_rr_contention();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m0_req = (i < 4); m1_req = (i < 4); m0_addr = 32'hA0; m1_addr = 32'hB0;
      mem_req_ack = 1'b1;
      mem_resp = (i == 0) ? SCR1_MEM_RESP_NOTRDY : SCR1_MEM_RESP_RDY_OK;
      #1;
      if (i < 4) begin
        n_checks++;
        if ({mem_req_w[0], m0_ack_w[0], m1_ack_w[0], mem_addr_w[0]} !==
            {1'b1, (i % 2) == 0, (i % 2) == 1, ((i % 2) == 0) ? 32'hA0 : 32'hB0}) begin
          n_fail++; $display("FAIL rr_grant_%0d: got req=%b a0=%b a1=%b addr=%h", i,
                             mem_req_w[0], m0_ack_w[0], m1_ack_w[0], mem_addr_w[0]);
        end
      end
      if (i > 0) begin
        n_checks++;
        if ((((i - 1) % 2) == 0 ? m0_resp_w[0] : m1_resp_w[0]) !== SCR1_MEM_RESP_RDY_OK) begin
          n_fail++; $display("FAIL rr_handoff_resp_%0d: got r0=%0d r1=%0d, expected RDY_OK on previous owner",
                             i, m0_resp_w[0], m1_resp_w[0]);
        end
      end
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m0_req = 1'b1; m1_req = 1'b1; mem_req_ack = 1'b1;
      mem_resp = (i == 0) ? SCR1_MEM_RESP_NOTRDY : SCR1_MEM_RESP_RDY_OK;
      #1;
      n_checks++;
      if ({m0_ack_w[1], m1_ack_w[1]} !== 2'b01) begin
        n_fail++; $display("FAIL fp_grant_%0d: got a0=%b a1=%b, expected 0/1", i, m0_ack_w[1], m1_ack_w[1]);
      end
      if (i > 0) begin
        n_checks++;
        if (m1_resp_w[1] !== SCR1_MEM_RESP_RDY_OK) begin
          n_fail++; $display("FAIL fp_resp_%0d: got %0d, expected 1", i, m1_resp_w[1]);
        end
      end
    end
  endtask

  task automatic test_error();
    do_reset();
    @(negedge clk);
    m1_req = 1'b1; m1_cmd = SCR1_MEM_CMD_WR; m1_wdata = 32'h5A5A; mem_req_ack = 1'b1;
    #1;
    n_checks++;
    if ({m1_ack_w[0], mem_cmd_w[0], mem_wdata_w[0]} !== {1'b1, SCR1_MEM_CMD_WR, 32'h5A5A}) begin
      n_fail++; $display("FAIL err_wr_addr: got a1=%b cmd=%0d wd=%h, expected 1/1/5a5a",
                         m1_ack_w[0], mem_cmd_w[0], mem_wdata_w[0]);
    end
    @(negedge clk);
    m1_req = 1'b0; m0_req = 1'b1; mem_resp = SCR1_MEM_RESP_RDY_ER;
    #1;
    n_checks++;
    if ({m1_resp_w[0], m0_ack_w[0], mem_req_w[0]} !== {SCR1_MEM_RESP_RDY_ER, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL err_resp: got r1=%0d a0=%b req=%b, expected 2/0/0",
                         m1_resp_w[0], m0_ack_w[0], mem_req_w[0]);
    end
    @(negedge clk);
    mem_resp = SCR1_MEM_RESP_NOTRDY;
    #1;
    n_checks++;
    if ({mem_req_w[0], m0_ack_w[0]} !== 2'b11) begin
      n_fail++; $display("FAIL err_next_grant: got req=%b a0=%b, expected 1/1", mem_req_w[0], m0_ack_w[0]);
    end
    @(negedge clk);
    idle_inputs(); mem_resp = SCR1_MEM_RESP_RDY_OK;
  endtask

  task automatic test_watchdog();
    do_reset();
    @(negedge clk);
    m0_req = 1'b1; mem_req_ack = 1'b1;
    for (int dc = 1; dc <= 12; dc++) begin
      @(negedge clk);
      m0_req = 1'b0;
      m1_req = (dc >= 5); mem_req_ack = (dc >= 5);
      mem_resp = (dc == 11) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
      mem_rdata = 32'h1234;
      #1;
      n_checks++;
      if (m0_resp_w[0] !== ((dc == 4) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_NOTRDY) ||
          m1_resp_w[0] !== SCR1_MEM_RESP_NOTRDY) begin
        n_fail++; $display("FAIL wd_resp_dc%0d: got r0=%0d r1=%0d", dc, m0_resp_w[0], m1_resp_w[0]);
      end
      n_checks++;
      if (tmo_w[0] !== (dc == 5)) begin
        n_fail++; $display("FAIL wd_pulse_dc%0d: got %b, expected %b", dc, tmo_w[0], dc == 5);
      end
      n_checks++;
      if ({mem_req_w[0], m1_ack_w[0]} !== {dc == 12, dc == 12}) begin
        n_fail++; $display("FAIL wd_gate_dc%0d: got req=%b a1=%b", dc, mem_req_w[0], m1_ack_w[0]);
      end
    end
    @(negedge clk);
    idle_inputs(); mem_resp = SCR1_MEM_RESP_RDY_OK;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    m0_req = 1'b1; mem_req_ack = 1'b1;
    @(negedge clk);
    m0_req = 1'b0; mem_req_ack = 1'b0;
    #2;
    rst_n = 1'b0; mem_resp = SCR1_MEM_RESP_RDY_OK;
    #1;
    n_checks++;
    if ({m0_resp_w[0], m1_resp_w[0], mem_req_w[0], tmo_w[0]} !==
        {SCR1_MEM_RESP_NOTRDY, SCR1_MEM_RESP_NOTRDY, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL mid_reset: got r0=%0d r1=%0d req=%b tmo=%b, expected 0/0/0/0",
                         m0_resp_w[0], m1_resp_w[0], mem_req_w[0], tmo_w[0]);
    end
    @(negedge clk);
    idle_inputs(); rst_n = 1'b1;
    @(negedge clk);
    m0_req = 1'b1; m1_req = 1'b1; mem_req_ack = 1'b1;
    #1;
    n_checks++;
    if ({m0_ack_w[0], m1_ack_w[0]} !== 2'b10) begin
      n_fail++; $display("FAIL mid_reset_first_grant: got a0=%b a1=%b, expected 1/0", m0_ack_w[0], m1_ack_w[0]);
    end
    @(negedge clk);
    idle_inputs(); mem_resp = SCR1_MEM_RESP_RDY_OK;
  endtask

  // Transaction-level reference: phase 0 idle, 1 awaiting response, 2 discarding a late response
  task automatic test_random();
    int  ph [2];
    int  wt [2];
    bit  own [2];
    bit  lst [2];
    bit  pls [2];
    int  tmo [2];
    bit  rrm [2];
    bit  win, anyr, g, fire, e_mreq, e_a0, e_a1;
    type_scr1_mem_resp_e  e_r0, e_r1;
    logic [31:0]          e_d0, e_d1, e_addr, e_wd;
    type_scr1_mem_cmd_e   e_cmd;
    type_scr1_mem_width_e e_wid;
    int r;
    tmo[0] = 4; tmo[1] = 0; rrm[0] = 1'b1; rrm[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; wt[k] = 0; own[k] = 1'b0; lst[k] = 1'b1; pls[k] = 1'b0;
    end
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      m0_req = ($urandom % 4) != 0; m1_req = ($urandom % 3) != 0;
      m0_cmd = ($urandom % 2) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
      m1_cmd = ($urandom % 2) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
      m0_width = type_scr1_mem_width_e'($urandom_range(0, 2));
      m1_width = type_scr1_mem_width_e'($urandom_range(0, 2));
      m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
      mem_req_ack = ($urandom % 3) != 0; mem_rdata = $urandom;
      r = $urandom_range(0, 7);
      mem_resp = (r < 4) ? SCR1_MEM_RESP_NOTRDY : ((r < 7) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER);
      #1;
      for (int k = 0; k < 2; k++) begin
        anyr = m0_req || m1_req;
        win  = (ph[k] == 0) || (ph[k] == 1 && mem_resp == SCR1_MEM_RESP_RDY_OK);
        if (m0_req && m1_req) g = rrm[k] ? (lst[k] == 1'b0) : 1'b1;
        else g = m1_req;
        e_mreq = win && anyr;
        e_a0 = e_mreq && mem_req_ack && !g;
        e_a1 = e_mreq && mem_req_ack && g;
        e_cmd = !anyr ? SCR1_MEM_CMD_ERROR : (g ? m1_cmd : m0_cmd);
        e_wid = !anyr ? SCR1_MEM_WIDTH_ERROR : (g ? m1_width : m0_width);
        e_addr = !anyr ? 32'h0 : (g ? m1_addr : m0_addr);
        e_wd = !anyr ? 32'h0 : (g ? m1_wdata : m0_wdata);
        fire = (tmo[k] != 0) && ph[k] == 1 && mem_resp == SCR1_MEM_RESP_NOTRDY && wt[k] == tmo[k] - 1;
        e_r0 = SCR1_MEM_RESP_NOTRDY; e_r1 = SCR1_MEM_RESP_NOTRDY; e_d0 = 32'h0; e_d1 = 32'h0;
        if (ph[k] == 1) begin
          if (own[k]) begin e_r1 = fire ? SCR1_MEM_RESP_RDY_ER : mem_resp; e_d1 = mem_rdata; end
          else        begin e_r0 = fire ? SCR1_MEM_RESP_RDY_ER : mem_resp; e_d0 = mem_rdata; end
        end
        n_checks++;
        if ({mem_req_w[k], m0_ack_w[k], m1_ack_w[k]} !== {e_mreq, e_a0, e_a1}) begin
          n_fail++; $display("FAIL rand_hs k=%0d cyc=%0d: got %b%b%b expected %b%b%b", k, cyc,
                             mem_req_w[k], m0_ack_w[k], m1_ack_w[k], e_mreq, e_a0, e_a1);
        end
        n_checks++;
        if ({m0_resp_w[k], m0_rdata_w[k], m1_resp_w[k], m1_rdata_w[k]} !== {e_r0, e_d0, e_r1, e_d1}) begin
          n_fail++; $display("FAIL rand_resp k=%0d cyc=%0d: got %0d/%h %0d/%h expected %0d/%h %0d/%h", k, cyc,
                             m0_resp_w[k], m0_rdata_w[k], m1_resp_w[k], m1_rdata_w[k], e_r0, e_d0, e_r1, e_d1);
        end
        n_checks++;
        if ({mem_cmd_w[k], mem_width_w[k], mem_addr_w[k], mem_wdata_w[k]} !== {e_cmd, e_wid, e_addr, e_wd}) begin
          n_fail++; $display("FAIL rand_fields k=%0d cyc=%0d: got %0d/%0d/%h/%h expected %0d/%0d/%h/%h", k, cyc,
                             mem_cmd_w[k], mem_width_w[k], mem_addr_w[k], mem_wdata_w[k], e_cmd, e_wid, e_addr, e_wd);
        end
        n_checks++;
        if (tmo_w[k] !== pls[k]) begin
          n_fail++; $display("FAIL rand_timeout k=%0d cyc=%0d: got %b expected %b", k, cyc, tmo_w[k], pls[k]);
        end
        pls[k] = fire;
        if (e_mreq && mem_req_ack) begin
          ph[k] = 1; own[k] = g; lst[k] = g; wt[k] = 0;
        end else if (ph[k] == 1) begin
          if (mem_resp != SCR1_MEM_RESP_NOTRDY) ph[k] = 0;
          else if (fire) ph[k] = 2;
          else wt[k] = wt[k] + 1;
        end else if (ph[k] == 2 && mem_resp != SCR1_MEM_RESP_NOTRDY) begin
          ph[k] = 0;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_contention();
    test_fixed_priority();
    test_error();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
